// File: rtl/ds_pkg.sv
// Shared FSM state type, mode encodings and geometry helpers for the downsample engine.
// No logic of its own; imported by the engine and its address generator.
package ds_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ACC,
        FLUSH,
        DONE
    } ds_state_t;

    localparam logic MODE_DECIMATE = 1'b0;
    localparam logic MODE_AVERAGE  = 1'b1;

    // Output image dimension for an input dimension reduced by 2^factor_log2.
    function automatic int out_dim(input int img_dim, input int factor_log2);
        return img_dim >> factor_log2;
    endfunction

    // Reads per output pixel: a full FxF block when averaging, one tap when decimating.
    function automatic int taps(input logic avg, input int factor_log2);
        return avg ? (1 << (2 * factor_log2)) : 1;
    endfunction

endpackage

// File: rtl/ds_addr_gen.sv
// Tap/block walker producing the input read address and the output pixel index.
// Latency: mi_add follows the registered counters combinationally; one tap per step.
// Backpressure: none; advances only when step/out_adv are pulsed by the FSM.
module ds_addr_gen
    import ds_pkg::*;
#(
    parameter int ADDR_W      = 19,
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int FACTOR_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic              avg,
    input  logic              out_adv,
    output logic [ADDR_W-1:0] mi_add,
    output logic [ADDR_W-1:0] out_idx,
    output logic              tap_first,
    output logic              tap_last,
    output logic              blk_last
);

    localparam int F     = 1 << FACTOR_LOG2;
    localparam int OUT_W = out_dim(IMG_W, FACTOR_LOG2);
    localparam int OUT_H = out_dim(IMG_H, FACTOR_LOG2);

    // Constant strides; every address is reached by adding one of these.
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W - (F - 1));
    localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(F);
    localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(F + (F - 1) * IMG_W);
    localparam logic [ADDR_W-1:0] OX_MAX    = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST  = ADDR_W'(OUT_W * OUT_H - 1);

    logic [FACTOR_LOG2-1:0] dx, dy;
    logic [ADDR_W-1:0]      ox;
    logic [ADDR_W-1:0]      blk_base;
    logic [ADDR_W-1:0]      tap_addr;
    logic [ADDR_W-1:0]      next_base;

    assign tap_first = (dx == '0) && (dy == '0);
    assign tap_last  = !avg || ((&dx) && (&dy));
    assign blk_last  = (out_idx == OUT_LAST);
    assign next_base = blk_base + ((ox == OX_MAX) ? WRAP_STEP : BLK_STEP);
    assign mi_add    = tap_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx       <= '0;
            dy       <= '0;
            ox       <= '0;
            blk_base <= '0;
            tap_addr <= '0;
            out_idx  <= '0;
        end else if (clear) begin
            dx       <= '0;
            dy       <= '0;
            ox       <= '0;
            blk_base <= '0;
            tap_addr <= '0;
            out_idx  <= '0;
        end else begin
            if (step) begin
                if (tap_last) begin
                    dx       <= '0;
                    dy       <= '0;
                    ox       <= (ox == OX_MAX) ? '0 : ox + ADDR_W'(1);
                    blk_base <= next_base;
                    tap_addr <= next_base;
                end else if (&dx) begin
                    dx       <= '0;
                    dy       <= dy + FACTOR_LOG2'(1);
                    tap_addr <= tap_addr + ROW_STEP;
                end else begin
                    dx       <= dx + FACTOR_LOG2'(1);
                    tap_addr <= tap_addr + ADDR_W'(1);
                end
            end
            if (out_adv) begin
                out_idx <= out_idx + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/downsample_engine.sv
// Reduces a raster image by 2^FACTOR_LOG2 per axis (decimate or box-average); DS_ROUND_EN rounds averages half up.
// Latency: T reads + 1 accumulate cycle per output pixel, write strobe one cycle later.
// Backpressure: none; memories are assumed always ready, START_FLAG/END_FLAG level handshake.
module downsample_engine
    import ds_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 19,
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int FACTOR_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              START_FLAG,
    input  logic              MODE,
    output logic              END_FLAG,
    input  logic [DATA_W-1:0] MI_data,
    output logic [ADDR_W-1:0] MI_add,
    output logic              RD_MI,
    output logic [DATA_W-1:0] MO_data,
    output logic [ADDR_W-1:0] MO_add,
    output logic              WR_MO
);

    localparam int SH = 2 * FACTOR_LOG2;
`ifdef DS_ROUND_EN
    // One spare bit so sum + half can never wrap.
    localparam int ACC_W = DATA_W + SH + 1;
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (SH - 1);
`else
    localparam int ACC_W = DATA_W + SH;
    localparam logic [ACC_W-1:0] RND = '0;
`endif

    ds_state_t         state;
    logic              mode_avg;
    logic              cap_vld;
    logic              cap_first;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum_all;
    logic [ADDR_W-1:0] out_idx;
    logic              tap_first;
    logic              tap_last;
    logic              blk_last;
    logic              start;
    logic              out_adv;

    assign start   = (state == IDLE) && START_FLAG;
    assign out_adv = (state == ACC);
    assign RD_MI   = (state == READ);
    // In ACC the last tap is still on MI_data, so fold it in combinationally.
    assign sum_all = acc + ACC_W'(MI_data) + RND;

    ds_addr_gen #(
        .ADDR_W      (ADDR_W),
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .FACTOR_LOG2 (FACTOR_LOG2)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (start),
        .step      (RD_MI),
        .avg       (mode_avg),
        .out_adv   (out_adv),
        .mi_add    (MI_add),
        .out_idx   (out_idx),
        .tap_first (tap_first),
        .tap_last  (tap_last),
        .blk_last  (blk_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_avg  <= MODE_DECIMATE;
            cap_vld   <= 1'b0;
            cap_first <= 1'b0;
            acc       <= '0;
            MO_data   <= '0;
            MO_add    <= '0;
            WR_MO     <= 1'b0;
            END_FLAG  <= 1'b0;
        end else begin
            cap_vld   <= RD_MI;
            cap_first <= tap_first;
            WR_MO     <= 1'b0;
            if (cap_vld) begin
                acc <= cap_first ? ACC_W'(MI_data) : acc + ACC_W'(MI_data);
            end
            case (state)
                IDLE: begin
                    if (START_FLAG) begin
                        mode_avg <= MODE;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (tap_last) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    MO_data <= (mode_avg == MODE_AVERAGE) ? DATA_W'(sum_all >> SH) : MI_data;
                    MO_add  <= out_idx;
                    WR_MO   <= 1'b1;
                    state   <= blk_last ? FLUSH : READ;
                end
                FLUSH: begin
                    state    <= DONE;
                    END_FLAG <= 1'b1;
                end
                DONE: begin
                    if (!START_FLAG) begin
                        state    <= IDLE;
                        END_FLAG <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_downsample_engine.sv
// Directed bench for downsample_engine: 4x4/F=2 instance checked cycle by cycle against a
// pixel-level model, plus an 8x8/F=4 all-255 instance for the accumulator range.
module tb_downsample_engine;

`ifdef DS_ROUND_EN
    localparam int RND  = 2;
    localparam int PIN0 = 26;
`else
    localparam int RND  = 0;
    localparam int PIN0 = 25;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        START_FLAG, MODE, END_FLAG, RD_MI, WR_MO;
    logic [7:0]  MI_data, MO_data;
    logic [18:0] MI_add, MO_add;

    logic        st4, mode4, end4, rd4, wr4;
    logic [7:0]  mi4_data, mo4_data;
    logic [18:0] mi4_add, mo4_add;

    downsample_engine #(
        .DATA_W(8), .ADDR_W(19), .IMG_W(4), .IMG_H(4), .FACTOR_LOG2(1)
    ) dut (
        .clk(clk), .rst(rst), .START_FLAG(START_FLAG), .MODE(MODE), .END_FLAG(END_FLAG),
        .MI_data(MI_data), .MI_add(MI_add), .RD_MI(RD_MI),
        .MO_data(MO_data), .MO_add(MO_add), .WR_MO(WR_MO)
    );

    downsample_engine #(
        .DATA_W(8), .ADDR_W(19), .IMG_W(8), .IMG_H(8), .FACTOR_LOG2(2)
    ) dut4 (
        .clk(clk), .rst(rst), .START_FLAG(st4), .MODE(mode4), .END_FLAG(end4),
        .MI_data(mi4_data), .MI_add(mi4_add), .RD_MI(rd4),
        .MO_data(mo4_data), .MO_add(mo4_add), .WR_MO(wr4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [16];
    always @(posedge clk) if (RD_MI) MI_data <= mem[MI_add[3:0]];
    always @(posedge clk) if (rd4) mi4_data <= 8'hFF;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected behaviour per cycle relative to the start cycle.
    bit  exp_rd [64];
    int  exp_ma [64];
    bit  exp_wr [64];
    int  exp_oa [64];
    int  exp_od [64];
    int  end_rel, win_end, s_cyc;
    bit  active = 0;
    bit  hold_m = 0;
    int  rel_now;
    assign rel_now = cyc - s_cyc;

    task automatic build_model(input bit avg);
        int tn, a, sum, first, c;
        tn = avg ? 4 : 1;
        for (int i = 0; i < 64; i++) begin
            exp_rd[i] = 0; exp_ma[i] = 0; exp_wr[i] = 0; exp_oa[i] = 0; exp_od[i] = 0;
        end
        for (int b = 0; b < 4; b++) begin
            sum = 0; first = 0;
            for (int t = 0; t < tn; t++) begin
                a = ((b / 2) * 2 + t / 2) * 4 + (b % 2) * 2 + t % 2;
                c = 1 + b * (tn + 1) + t;
                exp_rd[c] = 1; exp_ma[c] = a;
                sum += mem[a];
                if (t == 0) first = mem[a];
            end
            c = 1 + b * (tn + 1) + tn + 1;
            exp_wr[c] = 1; exp_oa[c] = b;
            exp_od[c] = avg ? (sum + RND) / 4 : first;
        end
        end_rel = 1 + 4 * (tn + 1) + 1;
    endtask

    always @(negedge clk) begin
        if (active && rel_now >= 1 && rel_now <= win_end) begin
            chk("rd_mi", RD_MI, exp_rd[rel_now]);
            if (exp_rd[rel_now]) chk("mi_add", MI_add, exp_ma[rel_now]);
            chk("wr_mo", WR_MO, exp_wr[rel_now]);
            if (exp_wr[rel_now]) begin
                chk("mo_add", MO_add, exp_oa[rel_now]);
                chk("mo_data", MO_data, exp_od[rel_now]);
            end
            chk("end_flag", END_FLAG, hold_m ? (rel_now >= end_rel) : (rel_now == end_rel));
        end
    end

    // Runs one job; MODE is flipped after the start edge to prove it was latched.
    task automatic run_job(input bit avg, input bit hold, input bit repulse, input int stop_rel);
        int last;
        build_model(avg);
        hold_m  = hold;
        win_end = hold ? end_rel + 2 : end_rel + 1;
        last    = (stop_rel > 0) ? stop_rel : win_end + 1;
        @(posedge clk); #1;
        MODE = avg; START_FLAG = 1'b1; s_cyc = cyc; active = 1;
        while (cyc - s_cyc < last) begin
            @(posedge clk); #1;
            MODE = !avg;
            if (!hold) START_FLAG = repulse && (cyc - s_cyc == 3);
        end
        active = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_mi"},    RD_MI,    0);
        chk({tag, "_mi_add"},   MI_add,   0);
        chk({tag, "_wr_mo"},    WR_MO,    0);
        chk({tag, "_mo_data"},  MO_data,  0);
        chk({tag, "_mo_add"},   MO_add,   0);
        chk({tag, "_end_flag"}, END_FLAG, 0);
    endtask

    int seq [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int dec [4]  = '{0, 2, 8, 10};
    int wcy [4]  = '{6, 11, 16, 21};
    int nwr;
    bit done4;

    initial begin
        rst = 1'b0; START_FLAG = 1'b0; MODE = 1'b0; st4 = 1'b0; mode4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Average job on the reference image.
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 9 + 3);
        mem[0] = 8'd10; mem[1] = 8'd20; mem[4] = 8'd30; mem[5] = 8'd42;
        build_model(1'b1);
        chk("model_avg_px0", exp_od[6], PIN0);
        for (int k = 0; k < 16; k++) chk("model_avg_addr", exp_ma[1 + (k / 4) * 5 + k % 4], seq[k]);
        for (int k = 0; k < 4; k++) chk("model_avg_wr_cycle", exp_wr[wcy[k]], 1);
        chk("model_avg_end", end_rel, 22);
        run_job(1'b1, 1'b0, 1'b0, 0);

        // Decimate job, MI[i] = i.
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        build_model(1'b0);
        for (int k = 0; k < 4; k++) chk("model_dec_px", exp_od[3 + 2 * k], dec[k]);
        chk("model_dec_end", end_rel, 10);
        run_job(1'b0, 1'b0, 1'b0, 0);

        // Reset in cycle 8 of an average job, then a fresh job with a stray START in READ.
        for (int i = 0; i < 16; i++) mem[i] = 8'(255 - i * 16);
        run_job(1'b1, 1'b0, 1'b0, 8);
        chk("pre_reset_rd_mi", RD_MI, 1);
        rst = 1'b0;
        #1;
        check_zero("midjob_reset");
        @(posedge clk); #1;
        chk("in_reset_rd_mi", RD_MI, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset_rd_mi", RD_MI, 0);
        run_job(1'b1, 1'b0, 1'b1, 0);

        // START held high through DONE, then dropped.
        run_job(1'b1, 1'b1, 1'b0, 0);
        START_FLAG = 1'b0;
        @(negedge clk);
        chk("end_hold", END_FLAG, 1);
        @(posedge clk); #1;
        chk("end_release", END_FLAG, 0);
        chk("idle_rd_mi", RD_MI, 0);
        @(posedge clk); #1;
        chk("idle_stays_rd_mi", RD_MI, 0);
        chk("idle_stays_end", END_FLAG, 0);

        // All-255 image at F=4 must average to 255 without overflow.
        @(posedge clk); #1;
        mode4 = 1'b1; st4 = 1'b1;
        @(posedge clk); #1;
        st4 = 1'b0;
        nwr = 0; done4 = 0;
        for (int k = 0; k < 300 && !done4; k++) begin
            @(negedge clk);
            if (wr4) begin
                chk("stress_data", mo4_data, 255);
                chk("stress_add", mo4_add, nwr);
                nwr++;
            end
            if (end4) done4 = 1;
        end
        chk("stress_writes", nwr, 4);
        chk("stress_end", done4, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
